// File: rtl/dlsc_demosaic_vng6_pkg.sv
// dlsc_demosaic_vng6_pkg: shared VNG6 constants (group slot count, group/sum width helpers)
package dlsc_demosaic_vng6_pkg;
  localparam int VNG6_DG_SLOTS = 4;
  function automatic int vng6_dg_group_w(input int data);
    return VNG6_DG_SLOTS * (data + 1);
  endfunction
  function automatic int vng6_dg_sum_w(input int data);
    return data + 3;
  endfunction
endpackage

// File: rtl/dlsc_demosaic_vng6_gather_fifo.sv
// dlsc_demosaic_vng6_gather_fifo: W-bit DEPTH-entry FIFO; clk/rst_n/clk_en, wr_en/wr_data in, rd_ready/rd_valid/rd_data out, full
module dlsc_demosaic_vng6_gather_fifo #(
  parameter int W     = 47,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_ready,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          rd, wr;
  always_comb begin
    rd_valid = cnt != '0;
    full     = cnt == (AW+1)'(DEPTH);
    rd_data  = mem[rd_ptr];
    rd       = clk_en & rd_valid & rd_ready;
    wr       = clk_en & wr_en & (!full | rd);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
endmodule

// File: rtl/dlsc_demosaic_vng6_diag_green_gather.sv
// dlsc_demosaic_vng6_diag_green_gather: groups 4 diag_green estimates + sum into a FIFO; push in, valid/ready out, sticky overflow
module dlsc_demosaic_vng6_diag_green_gather
  import dlsc_demosaic_vng6_pkg::*;
#(
  parameter int DATA  = 8,
  parameter int DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clk_en,
  input  logic                               sync,
  input  logic                               diag_green_push,
  input  logic [DATA:0]                      diag_green,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [vng6_dg_group_w(DATA)-1:0]   out_data,
  output logic [vng6_dg_sum_w(DATA)-1:0]     out_sum,
  output logic                               overflow
);
  localparam int DW = DATA + 1;
  localparam int GW = vng6_dg_group_w(DATA);
  localparam int SW = vng6_dg_sum_w(DATA);
  logic [1:0]     slot;
  logic [DW-1:0]  a0, a1, a2;
  logic           complete, full, drop;
  logic [SW-1:0]  sum;
  logic [GW+SW-1:0] wdata, rdata;
  always_comb begin
    complete = diag_green_push & !sync & (slot == 2'd3);
    sum      = SW'(a0) + SW'(a1) + SW'(a2) + SW'(diag_green);
    wdata    = {sum, diag_green, a2, a1, a0};
    drop     = clk_en & complete & full & !out_ready;
  end
  assign {out_sum, out_data} = rdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot     <= '0;
      a0       <= '0;
      a1       <= '0;
      a2       <= '0;
      overflow <= 1'b0;
    end else if (clk_en) begin
      if (sync | diag_green_push) slot <= sync ? {1'b0, diag_green_push} : slot + 2'd1;
      if (diag_green_push & (sync | slot == 2'd0)) a0 <= diag_green;
      if (diag_green_push & !sync & slot == 2'd1) a1 <= diag_green;
      if (diag_green_push & !sync & slot == 2'd2) a2 <= diag_green;
      if (drop) overflow <= 1'b1;
    end
  dlsc_demosaic_vng6_gather_fifo #(.W(GW + SW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .wr_en    (complete),
    .wr_data  (wdata),
    .rd_ready (out_ready),
    .rd_valid (out_valid),
    .rd_data  (rdata),
    .full     (full)
  );
endmodule
